hdlc_rx_checker: RTL
====================

Name: hdlc_rx_checker

Overview:
- Synthesizable, parametrised protocol checker for the HDLC Rx path.
- Passively monitors the serial Rx line and the Rx status strobes, then checks four rules:
  - flag-detect latency
  - abort-signal response
  - end-of-frame generation
  - overflow after N received bytes
- Per-rule error pulses, a sticky error vector and a saturating error count are reported.
- Sits beside the Rx module in both sim and emulation builds, so errors are visible on hardware as well as in the bench.

Parameters:
- FLAG_LAT, 2: cycles from the last flag bit sampled on Rx to the required Rx_FlagDetect (legal range 1..4).
- OVF_BYTES, 126: number of Rx_NewByte strobes in a frame after which Rx_Overflow must assert.
- CNT_W, 16: width of the error counter (and of the pass counter when the optional feature is enabled).

Ports:
- Clk  in  1  system clock, rising edge
- Rst  in  1  synchronous reset, active-low
- Chk_En  in  1  1 = checks active; 0 = pipelines and FSM held cleared
- Clr_Cnt  in  1  synchronous clear of Err_Count and Err_Vec
- Rx  in  1  serial receive line
- Rx_FlagDetect  in  1  DUT flag-detected strobe
- Rx_AbortDetect  in  1  DUT abort-detected strobe
- Rx_AbortSignal  in  1  DUT abort status
- Rx_ValidFrame  in  1  DUT frame-valid level
- Rx_EoF  in  1  DUT end-of-frame strobe
- Rx_NewByte  in  1  DUT new-byte strobe
- Rx_Overflow  in  1  DUT overflow status
- Err_Pulse  out  4  one-cycle error pulse per rule: [0] flag, [1] abort, [2] eof, [3] overflow
- Err_Vec  out  4  sticky OR of Err_Pulse
- Err_Count  out  CNT_W  saturating total error count
- Chk_State  out  2  overflow-FSM state, for debug

Behaviour:
- Reset: synchronous on rising Clk while Rst==0. Reset values:
  - Err_Pulse=0, Err_Vec=0, Err_Count=0
  - Chk_State=IDLE
  - Shift register cleared to 8'h00
  - All latency pipelines cleared
- Chk_En=0 holds the same values except Err_Vec and Err_Count, which keep their contents. Reset mid-frame discards all pending checks.
- Pattern detection:
  - 8-bit shift register: sr <= {sr[6:0], Rx} every cycle; sr[0] is the newest bit.
  - Flag = sr==8'h7E. Abort pattern = sr==8'h7F.
  - The match is evaluated on the register value after edge k, where edge k is the edge that sampled the last bit.
- Rule 0, flag: for each flag match at edge k, Rx_FlagDetect must be 1 at edge k+FLAG_LAT, else Err_Pulse[0].
  - Tracked with a FLAG_LAT-deep shift pipeline, so back-to-back flags are each checked independently.
- Rule 1, abort: Rx_AbortDetect && Rx_ValidFrame sampled at edge k requires Rx_AbortSignal==1 at edge k+1, else Err_Pulse[1].
- Rule 2, eof: Rx_ValidFrame==1 at edge k-1 and 0 at edge k requires Rx_EoF==1 at edge k+1, else Err_Pulse[2].
  - Not checked when the fall was caused by an abort-pattern match within the preceding 2 cycles.
- Rule 3, overflow FSM (Chk_State encoding: IDLE=0, FRAME=1, CHECK=2, DRAIN=3):
  - IDLE -> FRAME on a flag match with Rx_ValidFrame==0; byte counter cleared to 0.
  - FRAME counts Rx_NewByte; counter width is $clog2(OVF_BYTES+1).
    - A flag or abort-pattern match -> IDLE. A flag while in FRAME restarts nothing.
    - Counter reaching OVF_BYTES -> CHECK.
  - CHECK (1 cycle): Rx_Overflow must be 1, else Err_Pulse[3]; then -> DRAIN.
  - DRAIN: waits for a flag or abort match -> IDLE.
  - A Rx_NewByte coinciding with a flag match in FRAME is counted before the exit takes effect.
- Error accounting:
  - Err_Count += popcount(Err_Pulse) each cycle, saturating at all-ones.
  - Err_Vec |= Err_Pulse.
  - Clr_Cnt has priority over a same-cycle increment: the result is 0, and that cycle's errors are dropped.
- Err_Pulse is registered: it asserts on the edge where the check fails, i.e. one cycle after the offending sample.

Optional Feature:
- Macro: HDLC_CHK_PASS_CNT_EN.
- When defined:
  - Adds output Pass_Count (CNT_W bits), incremented once per passed check.
  - Multiple passes in the same cycle add their popcount.
  - Saturating; cleared by reset and by Clr_Cnt.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package hdlc_chk_pkg holds:
  - FLAG_PAT=8'h7E and ABORT_PAT=8'h7F
  - enum chk_state_t {IDLE, FRAME, CHECK, DRAIN}
  - error-index constants ERR_FLAG=0, ERR_ABORT=1, ERR_EOF=2, ERR_OVF=3
- Sub-module hdlc_pattern_det: shift register plus the flag and abort match outputs, also reusable on the Tx line.

Test Plan:
- Rx bits 0,1,1,1,1,1,1,0, DUT pulses Rx_FlagDetect exactly 2 cycles after the last 0 -> Err_Pulse=0, Err_Count=0. Repeat with the pulse at 3 cycles -> Err_Pulse[0] once, Err_Count=1.
- Rx_ValidFrame=1 with Rx_AbortDetect=1 at edge k, Rx_AbortSignal held 0 -> Err_Pulse[1] at edge k+1, Err_Vec=4'b0010.
- Opening flag, 126 Rx_NewByte strobes, Rx_Overflow=1 in CHECK -> no error and Chk_State DRAIN then IDLE after the closing flag. Same sequence with Rx_Overflow=0 -> Err_Pulse[3].
- Rx_ValidFrame falls with no Rx_EoF -> Err_Pulse[2]. Falls after an abort pattern -> no error.
- CNT_W=2, force 5 errors -> Err_Count saturates at 3. Clr_Cnt asserted in the same cycle as an error -> Err_Count=0, Err_Vec=0.
- Rst=0 asserted mid-FRAME at byte 60 -> FSM IDLE, pipelines empty, no spurious Err_Pulse in the following cycles.

Source files
------------

// File: rtl/hdlc_chk_pkg.sv
// Shared constants, FSM state type and helpers for the HDLC Rx protocol checker.
package hdlc_chk_pkg;

  localparam logic [7:0] FLAG_PAT  = 8'h7E;
  localparam logic [7:0] ABORT_PAT = 8'h7F;

  // Overflow-rule FSM; encoding is visible on Chk_State
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    CHECK = 2'd2,
    DRAIN = 2'd3
  } chk_state_t;

  // Bit positions in Err_Pulse / Err_Vec
  localparam int unsigned ERR_FLAG  = 0;
  localparam int unsigned ERR_ABORT = 1;
  localparam int unsigned ERR_EOF   = 2;
  localparam int unsigned ERR_OVF   = 3;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] n;
    n = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    return n;
  endfunction

endpackage

// File: rtl/hdlc_pattern_det.sv
// Serial 8-bit shift register with flag / abort pattern match.
// Newest bit lands in bit 0; matches are combinational on the registered value.
module hdlc_pattern_det
  import hdlc_chk_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic bit_i,
  output logic flag_o,
  output logic abort_o
);

  logic [7:0] sr_q, sr_d;

  // Shift in one line bit per cycle; held cleared while disabled
  always_comb begin
    sr_d = {sr_q[6:0], bit_i};
    if (!en_i) sr_d = 8'h00;
  end

  // Shift register state (synchronous reset)
  always_ff @(posedge clk_i) begin
    if (!rst_ni) sr_q <= 8'h00;
    else         sr_q <= sr_d;
  end

  assign flag_o  = (sr_q == FLAG_PAT);
  assign abort_o = (sr_q == ABORT_PAT);

endmodule

// File: rtl/hdlc_rx_checker.sv
// Passive protocol checker for the HDLC Rx path: flag latency, abort response,
// end-of-frame generation and overflow after OVF_BYTES bytes.
// Optional build macro HDLC_CHK_PASS_CNT_EN adds a saturating Pass_Count output.
module hdlc_rx_checker
  import hdlc_chk_pkg::*;
#(
  parameter int unsigned FLAG_LAT  = 2,
  parameter int unsigned OVF_BYTES = 126,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Chk_En,
  input  logic             Clr_Cnt,
  input  logic             Rx,
  input  logic             Rx_FlagDetect,
  input  logic             Rx_AbortDetect,
  input  logic             Rx_AbortSignal,
  input  logic             Rx_ValidFrame,
  input  logic             Rx_EoF,
  input  logic             Rx_NewByte,
  input  logic             Rx_Overflow,
  output logic [3:0]       Err_Pulse,
  output logic [3:0]       Err_Vec,
  output logic [CNT_W-1:0] Err_Count,
  output logic [1:0]       Chk_State
`ifdef HDLC_CHK_PASS_CNT_EN
  ,
  output logic [CNT_W-1:0] Pass_Count
`endif
);

  localparam int unsigned BCNT_W = $clog2(OVF_BYTES + 1);
  localparam logic [BCNT_W-1:0] OVF_CNT = BCNT_W'(OVF_BYTES);
  localparam int unsigned SUM_W = CNT_W + 3;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [2:0] b);
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] res;
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum > CNT_MAX) res = '1;
    else               res = sum[CNT_W-1:0];
    return res;
  endfunction

  logic flag_match, abort_match;

  hdlc_pattern_det u_det (
    .clk_i   (Clk),
    .rst_ni  (Rst),
    .en_i    (Chk_En),
    .bit_i   (Rx),
    .flag_o  (flag_match),
    .abort_o (abort_match)
  );

  // ---------------------------------------------------------------------------
  // Rule 0: each flag match must be answered FLAG_LAT cycles later
  // ---------------------------------------------------------------------------
  logic flag_due;

  if (FLAG_LAT == 1) begin : g_flag_lat1
    assign flag_due = flag_match;
  end else begin : g_flag_latn
    logic [FLAG_LAT-2:0] flag_pipe_q, flag_pipe_d;

    // Every match marches one stage per cycle so back-to-back flags stay separate
    always_comb begin
      flag_pipe_d    = flag_pipe_q << 1;
      flag_pipe_d[0] = flag_match;
    end

    // Flag latency pipeline
    always_ff @(posedge Clk) begin
      if (!Rst || !Chk_En) flag_pipe_q <= '0;
      else                 flag_pipe_q <= flag_pipe_d;
    end

    assign flag_due = flag_pipe_q[FLAG_LAT-2];
  end

  // ---------------------------------------------------------------------------
  // Rules 1/2 pending flags and the overflow FSM
  // ---------------------------------------------------------------------------
  logic              abort_pend_q, abort_pend_d;
  logic              vf_q;
  logic              eof_pend_q, eof_pend_d;
  logic              abort_seen_q;
  chk_state_t        state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;

  // Pending abort/eof checks; a fall right after an abort pattern needs no EoF
  always_comb begin
    abort_pend_d = Rx_AbortDetect && Rx_ValidFrame;
    eof_pend_d   = vf_q && !Rx_ValidFrame && !(abort_match || abort_seen_q);
  end

  // Overflow FSM next state and byte counter
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      IDLE: begin
        if (flag_match && !Rx_ValidFrame) begin
          state_d = FRAME;
          bcnt_d  = '0;
        end
      end
      FRAME: begin
        // A byte arriving with the closing pattern is still counted
        if (Rx_NewByte) bcnt_d = bcnt_q + BCNT_W'(1);
        if (bcnt_d == OVF_CNT)                state_d = CHECK;
        else if (flag_match || abort_match)   state_d = IDLE;
      end
      CHECK: state_d = DRAIN;
      DRAIN: begin
        if (flag_match || abort_match) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Check-pipeline and FSM registers; disabled checker holds them cleared
  always_ff @(posedge Clk) begin
    if (!Rst || !Chk_En) begin
      abort_pend_q <= 1'b0;
      vf_q         <= 1'b0;
      eof_pend_q   <= 1'b0;
      abort_seen_q <= 1'b0;
      state_q      <= IDLE;
      bcnt_q       <= '0;
    end else begin
      abort_pend_q <= abort_pend_d;
      vf_q         <= Rx_ValidFrame;
      eof_pend_q   <= eof_pend_d;
      abort_seen_q <= abort_match;
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Rule evaluation and error accounting
  // ---------------------------------------------------------------------------
  logic [3:0]       err_d, err_q;
  logic [3:0]       vec_d, vec_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Evaluate all four rules against this cycle's DUT samples
  always_comb begin
    err_d = '0;
    if (Chk_En) begin
      err_d[ERR_FLAG]  = flag_due && !Rx_FlagDetect;
      err_d[ERR_ABORT] = abort_pend_q && !Rx_AbortSignal;
      err_d[ERR_EOF]   = eof_pend_q && !Rx_EoF;
      err_d[ERR_OVF]   = (state_q == CHECK) && !Rx_Overflow;
    end
  end

  // Sticky vector and saturating count; clear wins over same-cycle errors
  always_comb begin
    vec_d = vec_q | err_d;
    cnt_d = sat_add(cnt_q, popcount4(err_d));
    if (Clr_Cnt) begin
      vec_d = '0;
      cnt_d = '0;
    end
  end

  // Error outputs; Chk_En only gates new errors, history survives
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      err_q <= '0;
      vec_q <= '0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      vec_q <= vec_d;
      cnt_q <= cnt_d;
    end
  end

  assign Err_Pulse = err_q;
  assign Err_Vec   = vec_q;
  assign Err_Count = cnt_q;
  assign Chk_State = state_q;

`ifdef HDLC_CHK_PASS_CNT_EN
  logic [3:0]       pass_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;

  // Mirror of the rule evaluation counting successful checks
  always_comb begin
    pass_d = '0;
    if (Chk_En) begin
      pass_d[ERR_FLAG]  = flag_due && Rx_FlagDetect;
      pass_d[ERR_ABORT] = abort_pend_q && Rx_AbortSignal;
      pass_d[ERR_EOF]   = eof_pend_q && Rx_EoF;
      pass_d[ERR_OVF]   = (state_q == CHECK) && Rx_Overflow;
    end
    pass_cnt_d = Clr_Cnt ? '0 : sat_add(pass_cnt_q, popcount4(pass_d));
  end

  // Saturating pass counter
  always_ff @(posedge Clk) begin
    if (!Rst) pass_cnt_q <= '0;
    else      pass_cnt_q <= pass_cnt_d;
  end

  assign Pass_Count = pass_cnt_q;
`endif

endmodule
